hd_inference_scheduler: RTL and testbench
=========================================

// Module: hd_inference_scheduler
// PURPOSE
//  Sequences one HD inference: per encoded query chunk, sweeps the class memory for all active classes and
//  drives the similarity accumulators; after the last chunk, scans per-class scores and reports the argmax.
//  Sits between the encoder (chunk stream), class memory (read port) and the similarity accumulator array.
// PARAMETERS
//  CLA_ADDR_WIDTH  10  class-memory address width; address = chunk_idx*class_num + class_idx
//  NUM_CLASSES_MAX 26  largest legal class_num
//  NUM_CHUNKS      64  chunks per hypervector (>=1)
//  SCORE_WIDTH     16  signed accumulated similarity width
//  MEM_RD_LAT      1   class-memory read latency in cycles (>=1)
// PORTS
//  clk             in   1               clock
//  reset_in        in   1               synchronous, active-high reset
//  start           in   1               begin inference; honoured only in IDLE
//  class_num       in   5               active class count, sampled on accepted start
//  cfg_err         out  1               1-cycle pulse: start with class_num==0 or >NUM_CLASSES_MAX
//  busy            out  1               high in every state except IDLE
//  enc_chunk_valid in   1               encoder has a chunk ready
//  enc_chunk_ready out  1               high only in WAIT_CHUNK; chunk consumed when valid&ready
//  class_rd_en     out  1               class-memory read strobe
//  class_addrs     out  CLA_ADDR_WIDTH  class-memory read address
//  acc_clear       out  1               1-cycle pulse: zero all accumulators
//  acc_en          out  1               accumulate read data into accumulator acc_idx
//  acc_idx         out  5               target accumulator (class index)
//  score_rd_idx    out  5               score read index during SCAN
//  score_in        in   SCORE_WIDTH     signed score of score_rd_idx, valid 1 cycle after index
//  result_valid    out  1               result held until result_ready
//  result_ready    in   1               consumer accepts result
//  result_class    out  5               argmax class index
//  result_score    out  SCORE_WIDTH     winning score
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; counters 0. reset_in mid-inference aborts at the next edge, no result.
//  FSM IDLE -> WAIT_CHUNK -> SWEEP -> (WAIT_CHUNK | DRAIN) -> SCAN -> DONE -> IDLE.
//  IDLE: start & legal class_num -> latch class_num_q, pulse acc_clear, addr=0, chunk_idx=0, go WAIT_CHUNK.
//   Illegal class_num -> cfg_err pulse, stay IDLE. start outside IDLE ignored, no cfg_err.
//  WAIT_CHUNK: enc_chunk_ready=1; on handshake go SWEEP, class_idx=0.
//  SWEEP: one read per cycle, class_rd_en=1, class_addrs=addr, addr++ each cycle (never resets per chunk).
//   acc_en/acc_idx = class_rd_en/class_idx delayed exactly MEM_RD_LAT cycles (shift pipeline).
//   At class_idx==class_num_q-1: if chunk_idx==NUM_CHUNKS-1 go DRAIN, else chunk_idx++, go WAIT_CHUNK.
//   Sweep of C classes takes exactly C cycles; class_num_q==1 gives a 1-cycle sweep.
//  DRAIN: wait MEM_RD_LAT cycles so last acc_en issues; then SCAN.
//  SCAN: score_rd_idx steps 0..class_num_q-1, one per cycle; compare score_in one cycle later, signed.
//   Replace best only on strictly greater: ties keep lowest index. First score always loads best.
//   After last compare (class_num_q+1 cycles in SCAN) go DONE.
//  DONE: result_valid=1, result_class/score stable until result_ready; on result_ready -> IDLE, valid drops
//   next cycle. start coincident with result_ready is ignored (not IDLE yet).
//  Address wrap: addr is CLA_ADDR_WIDTH bits, wraps modulo 2^CLA_ADDR_WIDTH; configs with
//   NUM_CHUNKS*class_num > 2^CLA_ADDR_WIDTH are illegal and also raise cfg_err.
//  Total latency (encoder never stalls): 1 + NUM_CHUNKS*(1+C) + MEM_RD_LAT + C+1 cycles start->result_valid.
// STRUCTURE
//  hd_accel_pkg: CLA_ADDR_WIDTH, NUM_CLASSES_MAX, score_t (signed SCORE_WIDTH), sched_state_e enum.
//  Sub-module hd_argmax_tracker: clear/valid/idx/score in, best_idx/best_score out, strict-greater compare.
//  Top holds FSM, class/chunk/address counters and the MEM_RD_LAT acc_en delay line.
// TESTING
//  class_num=4, NUM_CHUNKS=2, encoder always valid -> addrs 0..3 then 4..7, acc_idx 0..3 twice, delayed 1.
//  scores {-5,12,7,12} -> result_class=1, result_score=12 (tie keeps lower index).
//  start with class_num=0 and with 27 -> cfg_err one cycle, busy stays 0, no reads.
//  encoder valid held low 10 cycles between chunks -> no class_rd_en while waiting; addr resumes at 4.
//  reset_in asserted mid-SWEEP -> next cycle all outputs 0, IDLE; new start runs clean, acc_clear pulses.
//  result_ready held low 20 cycles in DONE -> result stable; start pulses ignored; ready=1 -> IDLE.

Source files
------------

// File: rtl/hd_accel_pkg.sv
// Shared types and constants for the HD inference accelerator.
package hd_accel_pkg;

  localparam int unsigned CLA_ADDR_WIDTH  = 10;
  localparam int unsigned NUM_CLASSES_MAX = 26;
  localparam int unsigned SCORE_WIDTH     = 16;

  typedef logic signed [SCORE_WIDTH-1:0] score_t;

  typedef enum logic [2:0] {
    StIdle,
    StWaitChunk,
    StSweep,
    StDrain,
    StScan,
    StDone
  } sched_state_e;

  // A class count is usable only if it is non-zero, within the class-memory capacity and the
  // whole chunk x class address range fits without the address counter wrapping onto itself.
  function automatic logic cfg_legal(input logic [4:0] cn, input int unsigned chunks,
                                     input int unsigned addr_w);
    int unsigned cn32;
    int unsigned span;
    cn32 = 32'(cn);
    span = chunks * cn32;
    return (cn32 != 0) && (cn32 <= NUM_CLASSES_MAX) && (span <= (32'd1 << addr_w));
  endfunction

endpackage

// File: rtl/hd_argmax_tracker.sv
// Running signed argmax over a stream of (index, score) pairs. The first score after a clear
// always loads; later scores replace the best only when strictly greater, so ties keep the
// lowest index seen.
module hd_argmax_tracker #(
  parameter int unsigned SCORE_WIDTH = 16,
  parameter int unsigned IDX_WIDTH   = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear,
  input  logic                   i_valid,
  input  logic [IDX_WIDTH-1:0]   i_idx,
  input  logic [SCORE_WIDTH-1:0] i_score,
  output logic [IDX_WIDTH-1:0]   o_best_idx,
  output logic [SCORE_WIDTH-1:0] o_best_score
);

  logic                   r_have;
  logic [IDX_WIDTH-1:0]   r_best_idx;
  logic [SCORE_WIDTH-1:0] r_best_score;
  logic                   w_take;

  assign w_take = i_valid && (!r_have || ($signed(i_score) > $signed(r_best_score)));

  // Best-so-far register; clear wins over an incoming score.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      r_have       <= 1'b0;
      r_best_idx   <= '0;
      r_best_score <= '0;
    end else if (w_take) begin
      r_have       <= 1'b1;
      r_best_idx   <= i_idx;
      r_best_score <= i_score;
    end
  end

  assign o_best_idx   = r_best_idx;
  assign o_best_score = r_best_score;

endmodule

// File: rtl/hd_inference_scheduler.sv
// Sequences one HD inference: for every encoded chunk it sweeps the class memory across all
// active classes and steers the read data into the similarity accumulators, then scans the
// per-class scores and reports the argmax.
module hd_inference_scheduler #(
  parameter int unsigned CLA_ADDR_WIDTH = hd_accel_pkg::CLA_ADDR_WIDTH,
  parameter int unsigned NUM_CHUNKS     = 64,
  parameter int unsigned SCORE_WIDTH    = hd_accel_pkg::SCORE_WIDTH,
  parameter int unsigned MEM_RD_LAT     = 1
) (
  input  logic                      clk,
  input  logic                      reset_in,
  input  logic                      start,
  input  logic [4:0]                class_num,
  output logic                      cfg_err,
  output logic                      busy,
  input  logic                      enc_chunk_valid,
  output logic                      enc_chunk_ready,
  output logic                      class_rd_en,
  output logic [CLA_ADDR_WIDTH-1:0] class_addrs,
  output logic                      acc_clear,
  output logic                      acc_en,
  output logic [4:0]                acc_idx,
  output logic [4:0]                score_rd_idx,
  input  logic [SCORE_WIDTH-1:0]    score_in,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [4:0]                result_class,
  output logic [SCORE_WIDTH-1:0]    result_score
);

  import hd_accel_pkg::*;

  localparam int unsigned ChunkW = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int unsigned DrainW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;
  localparam logic [ChunkW-1:0] ChunkLast = ChunkW'(NUM_CHUNKS - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(MEM_RD_LAT - 1);

  sched_state_e              r_state, w_state_next;
  logic [4:0]                r_class_num, w_class_num_next;
  logic [4:0]                r_class_idx, w_class_idx_next;
  logic [ChunkW-1:0]         r_chunk_idx, w_chunk_idx_next;
  logic [CLA_ADDR_WIDTH-1:0] r_addr, w_addr_next;
  logic [DrainW-1:0]         r_drain_cnt, w_drain_cnt_next;
  logic [4:0]                r_scan_cnt, w_scan_cnt_next;

  logic                      r_cfg_err;
  logic                      r_acc_clear;
  logic [MEM_RD_LAT-1:0]     r_acc_en_pipe;
  logic [4:0]                r_acc_idx_pipe [MEM_RD_LAT];
  logic                      r_cmp_valid;
  logic [4:0]                r_cmp_idx;

  logic                      w_cfg_legal;
  logic                      w_idle;
  logic                      w_start_ok;
  logic                      w_start_bad;
  logic                      w_sweep_last;
  logic                      w_rd_en;
  logic                      w_scan_issue;
  logic [4:0]                w_best_idx;
  logic [SCORE_WIDTH-1:0]    w_best_score;

  assign w_cfg_legal  = cfg_legal(class_num, NUM_CHUNKS, CLA_ADDR_WIDTH);
  assign w_idle       = (r_state == StIdle);
  assign w_start_ok   = w_idle && start && w_cfg_legal;
  assign w_start_bad  = w_idle && start && !w_cfg_legal;
  assign w_sweep_last = (r_class_idx == (r_class_num - 5'd1));
  assign w_rd_en      = (r_state == StSweep);
  // Score indices are issued for the first class_num SCAN cycles; the extra cycle is the
  // compare of the last returned score.
  assign w_scan_issue = (r_state == StScan) && (r_scan_cnt < r_class_num);

  // Next-state and counter updates.
  always_comb begin
    w_state_next     = r_state;
    w_class_num_next = r_class_num;
    w_class_idx_next = r_class_idx;
    w_chunk_idx_next = r_chunk_idx;
    w_addr_next      = r_addr;
    w_drain_cnt_next = r_drain_cnt;
    w_scan_cnt_next  = r_scan_cnt;
    unique case (r_state)
      StIdle: begin
        if (w_start_ok) begin
          w_state_next     = StWaitChunk;
          w_class_num_next = class_num;
          w_addr_next      = '0;
          w_chunk_idx_next = '0;
        end
      end
      StWaitChunk: begin
        if (enc_chunk_valid) begin
          w_state_next     = StSweep;
          w_class_idx_next = '0;
        end
      end
      StSweep: begin
        // The address runs continuously across chunks; memory is laid out chunk-major.
        w_addr_next = r_addr + 1'b1;
        if (w_sweep_last) begin
          if (r_chunk_idx == ChunkLast) begin
            w_state_next     = StDrain;
            w_drain_cnt_next = '0;
          end else begin
            w_chunk_idx_next = r_chunk_idx + 1'b1;
            w_state_next     = StWaitChunk;
          end
        end else begin
          w_class_idx_next = r_class_idx + 5'd1;
        end
      end
      StDrain: begin
        if (r_drain_cnt == DrainLast) begin
          w_state_next    = StScan;
          w_scan_cnt_next = '0;
        end else begin
          w_drain_cnt_next = r_drain_cnt + 1'b1;
        end
      end
      StScan: begin
        if (r_scan_cnt == r_class_num) begin
          w_state_next = StDone;
        end else begin
          w_scan_cnt_next = r_scan_cnt + 5'd1;
        end
      end
      StDone: begin
        if (result_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, counters and single-cycle pulses.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_state     <= StIdle;
      r_class_num <= '0;
      r_class_idx <= '0;
      r_chunk_idx <= '0;
      r_addr      <= '0;
      r_drain_cnt <= '0;
      r_scan_cnt  <= '0;
      r_cfg_err   <= 1'b0;
      r_acc_clear <= 1'b0;
      r_cmp_valid <= 1'b0;
      r_cmp_idx   <= '0;
    end else begin
      r_state     <= w_state_next;
      r_class_num <= w_class_num_next;
      r_class_idx <= w_class_idx_next;
      r_chunk_idx <= w_chunk_idx_next;
      r_addr      <= w_addr_next;
      r_drain_cnt <= w_drain_cnt_next;
      r_scan_cnt  <= w_scan_cnt_next;
      r_cfg_err   <= w_start_bad;
      r_acc_clear <= w_start_ok;
      r_cmp_valid <= w_scan_issue;
      r_cmp_idx   <= r_scan_cnt;
    end
  end

  // Delay line aligning acc_en/acc_idx with read data returning from the class memory.
  always_ff @(posedge clk) begin
    if (reset_in) begin
      r_acc_en_pipe <= '0;
      for (int i = 0; i < MEM_RD_LAT; i++) begin
        r_acc_idx_pipe[i] <= '0;
      end
    end else begin
      r_acc_en_pipe[0]  <= w_rd_en;
      r_acc_idx_pipe[0] <= w_rd_en ? r_class_idx : 5'd0;
      for (int i = 1; i < MEM_RD_LAT; i++) begin
        r_acc_en_pipe[i]  <= r_acc_en_pipe[i-1];
        r_acc_idx_pipe[i] <= r_acc_idx_pipe[i-1];
      end
    end
  end

  hd_argmax_tracker #(
    .SCORE_WIDTH (SCORE_WIDTH),
    .IDX_WIDTH   (5)
  ) u_argmax (
    .i_clk        (clk),
    .i_reset      (reset_in),
    .i_clear      (w_start_ok),
    .i_valid      (r_cmp_valid),
    .i_idx        (r_cmp_idx),
    .i_score      (score_in),
    .o_best_idx   (w_best_idx),
    .o_best_score (w_best_score)
  );

  assign cfg_err         = r_cfg_err;
  assign busy            = !w_idle;
  assign enc_chunk_ready = (r_state == StWaitChunk);
  assign class_rd_en     = w_rd_en;
  assign class_addrs     = w_rd_en ? r_addr : '0;
  assign acc_clear       = r_acc_clear;
  assign acc_en          = r_acc_en_pipe[MEM_RD_LAT-1];
  assign acc_idx         = r_acc_idx_pipe[MEM_RD_LAT-1];
  assign score_rd_idx    = w_scan_issue ? r_scan_cnt : 5'd0;
  assign result_valid    = (r_state == StDone);
  assign result_class    = (r_state == StDone) ? w_best_idx : 5'd0;
  assign result_score    = (r_state == StDone) ? w_best_score : '0;

endmodule

// File: tb/tb_hd_inference_scheduler.sv
// Directed bench for hd_inference_scheduler with NUM_CHUNKS=2 and a one-cycle memory.
module tb_hd_inference_scheduler;

  localparam int unsigned NCH = 2;
  localparam int unsigned AW  = 10;
  localparam int unsigned SW  = 16;

  logic          clk = 1'b0;
  logic          reset_in = 1'b1;
  logic          start = 1'b0;
  logic [4:0]    class_num = '0;
  logic          cfg_err, busy;
  logic          enc_chunk_valid = 1'b0;
  logic          enc_chunk_ready;
  logic          class_rd_en;
  logic [AW-1:0] class_addrs;
  logic          acc_clear, acc_en;
  logic [4:0]    acc_idx, score_rd_idx;
  logic [SW-1:0] score_in = '0;
  logic          result_valid;
  logic          result_ready = 1'b0;
  logic [4:0]    result_class;
  logic [SW-1:0] result_score;

  always #5 clk = ~clk;

  hd_inference_scheduler #(
    .CLA_ADDR_WIDTH (AW),
    .NUM_CHUNKS     (NCH),
    .SCORE_WIDTH    (SW),
    .MEM_RD_LAT     (1)
  ) dut (
    .clk             (clk),
    .reset_in        (reset_in),
    .start           (start),
    .class_num       (class_num),
    .cfg_err         (cfg_err),
    .busy            (busy),
    .enc_chunk_valid (enc_chunk_valid),
    .enc_chunk_ready (enc_chunk_ready),
    .class_rd_en     (class_rd_en),
    .class_addrs     (class_addrs),
    .acc_clear       (acc_clear),
    .acc_en          (acc_en),
    .acc_idx         (acc_idx),
    .score_rd_idx    (score_rd_idx),
    .score_in        (score_in),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .result_class    (result_class),
    .result_score    (result_score)
  );

  typedef struct {
    int cn;
    int sc[26];
    int stall;
    int rdy;
    int exp_c;
    int exp_s;
  } vec_t;

  localparam int NV = 9;
  vec_t vt[NV];

  int n_vec = 0;
  int n_err = 0;
  logic signed [SW-1:0] mem [32];
  logic [4:0] prev_sidx = '0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample at the falling edge and return the score for last cycle's index.
  task automatic cyc();
    @(negedge clk);
    score_in  = mem[prev_sidx];
    prev_sidx = score_rd_idx;
  endtask

  task automatic check_quiet(input string name);
    check({name, ".busy"}, 32'(busy), 0);
    check({name, ".outs"}, 32'({enc_chunk_ready, class_rd_en, class_addrs, acc_clear, acc_en,
                                acc_idx, score_rd_idx, result_valid, result_class,
                                result_score}), 0);
  endtask

  task automatic set_vec(input int k, input int cn, input int stall, input int rdy,
                         input int ec, input int es);
    vt[k].cn    = cn;
    vt[k].stall = stall;
    vt[k].rdy   = rdy;
    vt[k].exp_c = ec;
    vt[k].exp_s = es;
    for (int i = 0; i < 26; i++) vt[k].sc[i] = 0;
  endtask

  task automatic run_inference(input vec_t v);
    int n, hs, wcnt, reads, exp_addr, exp_ci, prev_ci, lat;
    logic prev_rd, done;
    for (int i = 0; i < 32; i++) mem[i] = (i < v.cn) ? SW'(v.sc[i]) : 16'sh7fff;
    lat = 1 + NCH * (1 + v.cn) + 1 + v.cn + 1 + v.stall * (NCH - 1);
    cyc();
    start = 1'b1; class_num = 5'(v.cn); result_ready = 1'b0; enc_chunk_valid = 1'b0;
    n = 0; hs = 0; wcnt = 0; reads = 0; exp_addr = 0; exp_ci = 0; prev_ci = 0;
    prev_rd = 1'b0; done = 1'b0;
    while (!done && n < 2000) begin
      cyc();
      n++;
      start = 1'b0;
      if (n == 1) check("acc_clear_pulse", 32'(acc_clear), 1);
      else if (acc_clear) check("acc_clear_extra", 32'(acc_clear), 0);
      if (acc_en !== prev_rd) check("acc_en_delay", 32'(acc_en), 32'(prev_rd));
      if (prev_rd) check("acc_idx", 32'(acc_idx), prev_ci);
      if (class_rd_en) begin
        check("class_addr", 32'(class_addrs), exp_addr);
        exp_addr++;
        prev_ci = exp_ci;
        exp_ci  = (exp_ci + 1) % v.cn;
        reads++;
      end
      prev_rd = class_rd_en;
      if (enc_chunk_ready) begin
        if (class_rd_en) check("rd_while_waiting", 32'(class_rd_en), 0);
        if (hs == 0 || wcnt >= v.stall) begin
          enc_chunk_valid = 1'b1; hs++; wcnt = 0;
        end else begin
          enc_chunk_valid = 1'b0; wcnt++;
        end
      end else begin
        enc_chunk_valid = 1'b0;
      end
      if (result_valid) done = 1'b1;
    end
    enc_chunk_valid = 1'b0;
    check("result_valid_seen", 32'(done), 1);
    check("latency", n, lat);
    check("read_count", reads, NCH * v.cn);
    check("result_class", 32'(result_class), v.exp_c);
    check("result_score", 32'($signed(result_score)), v.exp_s);
    for (int i = 0; i < v.rdy; i++) begin
      cyc();
      start = (i % 5 == 2); class_num = 5'd3;
      check("hold_valid", 32'(result_valid), 1);
      check("hold_class", 32'(result_class), v.exp_c);
      check("hold_score", 32'($signed(result_score)), v.exp_s);
    end
    start = 1'b1; class_num = 5'd3; result_ready = 1'b1;
    cyc();
    start = 1'b0; result_ready = 1'b0;
    check("valid_drop", 32'(result_valid), 0);
    check("busy_after_ready", 32'(busy), 0);
    cyc();
    check("coincident_start_ignored", 32'({busy, acc_clear}), 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = '0;
    set_vec(0, 4, 0, 0, 1, 12);
    vt[0].sc[0] = -5; vt[0].sc[1] = 12; vt[0].sc[2] = 7; vt[0].sc[3] = 12;
    set_vec(1, 1, 0, 0, 0, -3);
    vt[1].sc[0] = -3;
    set_vec(2, 5, 0, 0, 2, -3);
    vt[2].sc[0] = -10; vt[2].sc[1] = -20; vt[2].sc[2] = -3; vt[2].sc[3] = -3;
    vt[2].sc[4] = -50;
    set_vec(3, 3, 0, 0, 0, -32768);
    vt[3].sc[0] = -32768; vt[3].sc[1] = -32768; vt[3].sc[2] = -32768;
    set_vec(4, 6, 0, 0, 5, 30000);
    vt[4].sc[0] = 1; vt[4].sc[1] = 2; vt[4].sc[2] = 3; vt[4].sc[3] = 4; vt[4].sc[4] = 5;
    vt[4].sc[5] = 30000;
    set_vec(5, 2, 0, 0, 0, 100);
    vt[5].sc[0] = 100; vt[5].sc[1] = -100;
    set_vec(6, 4, 10, 0, 1, 12);
    vt[6].sc[0] = -5; vt[6].sc[1] = 12; vt[6].sc[2] = 7; vt[6].sc[3] = 12;
    set_vec(7, 4, 0, 20, 2, 9);
    vt[7].sc[0] = 3; vt[7].sc[1] = -1; vt[7].sc[2] = 9; vt[7].sc[3] = 0;
    set_vec(8, 26, 0, 0, 25, 35);
    for (int i = 0; i < 26; i++) vt[8].sc[i] = i * 3 - 40;

    // Reset state
    repeat (3) cyc();
    check_quiet("reset");
    check("reset.cfg_err", 32'(cfg_err), 0);
    reset_in = 1'b0;
    cyc();
    check_quiet("idle");

    // Illegal class counts
    begin
      int bad[3];
      bad[0] = 0; bad[1] = 27; bad[2] = 31;
      for (int k = 0; k < 3; k++) begin
        start = 1'b1; class_num = 5'(bad[k]);
        cyc();
        start = 1'b0;
        check("cfg_err_pulse", 32'(cfg_err), 1);
        check_quiet("cfg_err_idle");
        cyc();
        check("cfg_err_one_cycle", 32'(cfg_err), 0);
        check("cfg_err_busy", 32'(busy), 0);
      end
    end

    // Reset in the middle of a sweep
    begin
      logic hit;
      hit = 1'b0;
      start = 1'b1; class_num = 5'd4;
      for (int i = 0; i < 50 && !hit; i++) begin
        cyc();
        start = 1'b0;
        enc_chunk_valid = enc_chunk_ready;
        if (class_rd_en && class_addrs == 10'd2) hit = 1'b1;
      end
      check("reached_mid_sweep", 32'(hit), 1);
      reset_in = 1'b1; enc_chunk_valid = 1'b0;
      cyc();
      check_quiet("abort");
      check("abort.cfg_err", 32'(cfg_err), 0);
      reset_in = 1'b0;
    end

    for (int k = 0; k < NV; k++) run_inference(vt[k]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
